// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared state type and constant helpers for the button array
package btn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HELD,
        ST_LONG,
        ST_REPEAT
    } state_t;

    function automatic int sel_const(input int sim, input int hw_val, input int sim_val);
        return (sim != 0) ? sim_val : hw_val;
    endfunction

    // Never returns 0 so that every counter has at least one bit.
    function automatic int clog2(input longint v);
        int     r;
        longint p;
        r = 0;
        p = 1;
        while (p < v) begin
            p = p << 1;
            r++;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/button_array_processor_channel.sv
// rtl/button_array_processor_channel.sv - one button: synchroniser, debouncer, hold FSM
module button_channel
    import btn_pkg::*;
#(
    parameter int DEB  = 4,
    parameter int LONG = 16,
    parameter int RPT  = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic button_in,
    input  logic repeat_en,
    output logic level,
    output logic press,
    output logic release_pulse,
    output logic long_press
);

    localparam int DW = clog2(DEB + 1);
    localparam int HW = clog2(((LONG > RPT) ? LONG : RPT) + 1);

    logic          sync0_q, sync0_d, sync1_q, sync1_d;
    logic          stable_q, stable_d, level_q, level_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    state_t        state_q, state_d;
    logic          press_q, press_d, release_q, release_d, long_q, long_d;
    logic          rise, fall;

    always_comb begin
        sync0_d   = button_in;
        sync1_d   = sync0_q;
        stable_d  = stable_q;
        deb_cnt_d = '0;
        if (sync1_q != stable_q) begin
            if (deb_cnt_q == DW'(DEB - 1)) stable_d = ~stable_q;
            else                           deb_cnt_d = deb_cnt_q + 1'b1;
        end

        // level_q trails stable_q by a cycle, so their difference marks a debounced edge.
        level_d    = stable_q;
        rise       = stable_q & ~level_q;
        fall       = ~stable_q & level_q;
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        long_d     = 1'b0;

        if (fall) begin
            state_d    = ST_IDLE;
            release_d  = 1'b1;
            hold_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        state_d    = ST_HELD;
                        press_d    = 1'b1;
                        hold_cnt_d = '0;
                    end
                end
                ST_HELD: begin
                    if (hold_cnt_q == HW'(LONG - 1)) begin
                        state_d    = ST_LONG;
                        long_d     = 1'b1;
                        hold_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
                ST_LONG: begin
                    hold_cnt_d = '0;
                    if (repeat_en) begin
                        state_d = ST_REPEAT;
                        press_d = 1'b1;
                    end
                end
                default: begin
                    if (!repeat_en) begin
                        state_d    = ST_LONG;
                        hold_cnt_d = '0;
                    end else if (hold_cnt_q == HW'(RPT - 1)) begin
                        press_d    = 1'b1;
                        hold_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync0_q    <= 1'b0;
            sync1_q    <= 1'b0;
            stable_q   <= 1'b0;
            level_q    <= 1'b0;
            deb_cnt_q  <= '0;
            hold_cnt_q <= '0;
            state_q    <= ST_IDLE;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            long_q     <= 1'b0;
        end else begin
            sync0_q    <= sync0_d;
            sync1_q    <= sync1_d;
            stable_q   <= stable_d;
            level_q    <= level_d;
            deb_cnt_q  <= deb_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            state_q    <= state_d;
            press_q    <= press_d;
            release_q  <= release_d;
            long_q     <= long_d;
        end
    end

    assign level         = level_q;
    assign press         = press_q;
    assign release_pulse = release_q;
    assign long_press    = long_q;

endmodule

// File: rtl/button_array_processor.sv
// rtl/button_array_processor.sv - N independent debounced button channels
module button_array_processor
    import btn_pkg::*;
#(
    parameter int N        = 4,
    parameter int sim      = 0,
    parameter int DEB_HW   = 1000000,
    parameter int DEB_SIM  = 4,
    parameter int LONG_HW  = 50000000,
    parameter int LONG_SIM = 16,
    parameter int RPT_HW   = 10000000,
    parameter int RPT_SIM  = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] ButtonIn,
    input  logic [N-1:0] repeat_en,
    output logic [N-1:0] level,
    output logic [N-1:0] press,
    output logic [N-1:0] release_pulse,
    output logic [N-1:0] long_press
);

    localparam int DEB  = sel_const(sim, DEB_HW, DEB_SIM);
    localparam int LONG = sel_const(sim, LONG_HW, LONG_SIM);
    localparam int RPT  = sel_const(sim, RPT_HW, RPT_SIM);

    for (genvar g = 0; g < N; g++) begin : g_ch
        button_channel #(
            .DEB  (DEB),
            .LONG (LONG),
            .RPT  (RPT)
        ) u_ch (
            .clk           (clk),
            .reset         (reset),
            .button_in     (ButtonIn[g]),
            .repeat_en     (repeat_en[g]),
            .level         (level[g]),
            .press         (press[g]),
            .release_pulse (release_pulse[g]),
            .long_press    (long_press[g])
        );
    end

endmodule

// File: doc/button_array_processor.md
Name: button_array_processor

Overview:
- Parameterised N-channel successor to the single-button synchroniser/debouncer/pulse chain.
- Each channel synchronises a raw push-button, debounces it, and emits one-cycle press and release pulses.
- Each channel also emits a one-cycle long-press pulse and, when enabled per channel, auto-repeat press pulses while the button is held.
- Sits between board button pins and the control FSMs of the experiment top levels.

Parameters:
- N, 4: number of independent button channels (1..16).
- sim, 0: 1 selects the short *_SIM timing constants for simulation; 0 selects the *_HW constants.
- DEB_HW, 1000000: debounce stable-time in clk cycles (20 ms @ 50 MHz).
- DEB_SIM, 4: debounce stable-time used when sim=1.
- LONG_HW, 50000000: hold time before the long-press event (1 s).
- LONG_SIM, 16: long-press hold time used when sim=1.
- RPT_HW, 10000000: auto-repeat period (200 ms).
- RPT_SIM, 8: auto-repeat period used when sim=1.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- ButtonIn  in  N  raw asynchronous button levels, active-high.
- repeat_en  in  N  per-channel auto-repeat enable; synchronous to clk.
- level  out  N  debounced button level.
- press  out  N  one-cycle pulse on debounced press and on each auto-repeat.
- release  out  N  one-cycle pulse on debounced release.
- long_press  out  N  one-cycle pulse when the hold time reaches LONG.

Behaviour:
- Effective constants: DEB, LONG and RPT take the *_SIM values if sim=1, otherwise the *_HW values.
- Counter width for each counter is clog2(max+1) of its limit. No counter ever wraps: each saturates or is cleared.
- Reset (clk edge with reset=1) sets, in every channel:
  - both synchroniser flops to 0;
  - the stable level to 0 and all counters to 0;
  - the FSM to IDLE;
  - level, press, release and long_press to 0 the following cycle.
- Reset mid-operation aborts any debounce or hold in progress. No release pulse is generated.
- Synchroniser: 2-flop chain per channel. No other logic reads ButtonIn.
- Debouncer, per channel:
  - While the synchronised value differs from the stable level, deb_cnt increments.
  - Any cycle where the two agree clears deb_cnt.
  - When deb_cnt reaches DEB-1 and they still differ, the stable level toggles and deb_cnt clears.
  - A glitch shorter than DEB cycles never changes level.
- Latency: a clean rising edge sampled at edge k produces level=1 and press=1 in the cycle after edge k+DEB+2. Release behaves symmetrically with the release pulse.
- Press/release outputs are registered one-cycle pulses. press and release are never high in the same cycle on one channel.
- Hold FSM, per channel. States: IDLE, HELD, LONG, REPEAT.
  - IDLE → HELD on the stable rising edge. Emit press; clear hold_cnt.
  - HELD: hold_cnt increments each cycle. At hold_cnt == LONG-1, go to LONG, emit long_press, clear hold_cnt.
  - LONG: if repeat_en=1, go to REPEAT and emit press in the same transition, clear hold_cnt. Otherwise stay in LONG with hold_cnt held at 0.
  - REPEAT: hold_cnt counts. At RPT-1, emit press and clear hold_cnt. If repeat_en drops, return to LONG with no pulse.
  - Any state → IDLE on the stable falling edge. Emit release; clear hold_cnt. A release takes priority over a long-press or repeat event due in the same cycle, so neither of those fires.
- Channels are fully independent. Simultaneous events on different channels are all reported in the same cycle.
- repeat_en changes while in HELD have no effect until the LONG state is reached.

Decomposition:
- Package btn_pkg holds:
  - the FSM state enum (IDLE, HELD, LONG, REPEAT);
  - a function selecting the SIM or HW constant;
  - a clog2 helper.
- Sub-module button_channel contains one channel: synchroniser, debouncer, hold FSM and counters. It takes the effective DEB/LONG/RPT as parameters.
- button_array_processor is a generate loop of N button_channel instances.

Test Plan (sim=1, so DEB=4, LONG=16, RPT=8; N=4):
- Reset: hold reset for 3 cycles with ButtonIn=4'hF → all outputs 0 during reset. After release of reset, press[3:0] pulses once each, exactly DEB+3 cycles later.
- Bounce: ButtonIn[0] toggles with highs of 1, 2 and 3 cycles, then stays high → no press until the final stable high. Then exactly one press, at latency DEB+3.
- Long press, repeat_en=0: hold channel 1 for 40 cycles → one press, long_press 16 cycles after it, no further pulses, one release after the button drops.
- Auto-repeat, repeat_en[2]=1: hold for 60 cycles → press, then long_press, a press in the cycle after long_press, and further presses every 8 cycles until release.
- Release during long-press: button drops so the debounced fall coincides with hold_cnt=15 → release=1, long_press stays 0.
- Reset mid-hold: assert reset while channel 3 is in REPEAT → outputs 0 next cycle, no release pulse. With the button still high, a new press arrives DEB+3 cycles after reset is deasserted.
